// File: rtl/csr_uart.sv
// CSR-mapped 8N1 UART.
//
// One CSR at BASE_ADDR. A write (modify=01) while the transmitter is free
// queues wdata[7:0] for transmission; a read returns
// {22'b0, tx_busy, rx_valid, rx_data[7:0]} one cycle later and, when read=1,
// consumes the received byte (clears rx_valid). rdata/valid are zero when
// the block is not addressed so they can be ORed with other CSR responders.
//
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   read           CSR read strobe (consumes the received byte)
//   modify         CSR write op: 00 none, 01 write, 10 set, 11 clear
//   wdata, addr    CSR write data and address
//   rdata, valid   registered read data and address-hit flag
//   rx, tx         serial input (asynchronous) and output, idle high
//   AVOID_WARNING  read & |wdata, no functional meaning
module csr_uart #(
  parameter int unsigned CLOCK_RATE = 200_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter logic [11:0] BASE_ADDR  = 12'h7c0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [1:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  output logic        AVOID_WARNING
);

  localparam int unsigned Div  = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] DivLast  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Div / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  // CSR response
  logic        hit;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;

  // Transmitter
  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;   // 0 start, 1..8 data, 9 stop
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_done;
  logic            tx_start;

  // Receiver
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;

  assign hit           = (addr == BASE_ADDR);
  assign AVOID_WARNING = read & (|wdata);
  assign rdata         = rdata_q;
  assign valid         = valid_q;
  assign tx            = tx_q;

  always_comb begin
    valid_d = hit;
    rdata_d = hit ? {22'b0, tx_busy_q, rx_valid_q, rx_data_q} : 32'b0;
  end

  // Last cycle of the stop bit: the transmitter is free again, so a write in
  // this same cycle starts the next frame with no idle gap.
  assign tx_done  = tx_busy_q && (tx_cnt_q == DivLast) && (tx_bit_q == 4'd9);
  assign tx_start = hit && (modify == 2'b01) && (!tx_busy_q || tx_done);

  always_comb begin
    tx_d      = tx_q;
    tx_busy_d = tx_busy_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_data_d = tx_data_q;
    if (tx_busy_q) begin
      if (tx_cnt_q == DivLast) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          // Entering bit n: data bit n-1 for n in 1..8, stop bit for n = 9.
          tx_d = (tx_bit_q == 4'd8) ? 1'b1 : tx_data_q[tx_bit_q[2:0]];
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CntW'(1);
      end
    end
    if (tx_start) begin
      tx_data_d = wdata[7:0];
      tx_busy_d = 1'b1;
      tx_cnt_d  = '0;
      tx_bit_d  = 4'd0;
      tx_d      = 1'b0;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    // A consuming read clears the flag first so a byte completing in the
    // same cycle still sets it.
    rx_valid_d = (hit && read) ? 1'b0 : rx_valid_q;
    case (rx_state_q)
      StIdle: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = StStart;
          rx_cnt_d   = '0;
        end
      end
      StStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          // Line back high at mid start bit: treat as a glitch.
          rx_state_d = rx_s2_q ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = StStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (rx_cnt_q == DivLast) begin
          rx_cnt_d   = '0;
          rx_state_d = StIdle;
          if (rx_s2_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_csr_uart.sv
// Self-checking bench for csr_uart at DIV = 16 (CLOCK_RATE=16, BAUD_RATE=1).
module tb_csr_uart;

  localparam int Div = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  modify = 2'b00;
  logic [31:0] wdata = '0;
  logic [11:0] addr = '0;
  logic [31:0] rdata;
  logic        valid;
  logic        rx = 1'b1;
  logic        tx;
  logic        avoid_warning;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state of the receive buffer
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = '0;

  csr_uart #(
    .CLOCK_RATE(16),
    .BAUD_RATE (1),
    .BASE_ADDR (12'h7c0)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .read         (read),
    .modify       (modify),
    .wdata        (wdata),
    .addr         (addr),
    .rdata        (rdata),
    .valid        (valid),
    .rx           (rx),
    .tx           (tx),
    .AVOID_WARNING(avoid_warning)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serial frame, LSB = first bit on the line
  function automatic logic [9:0] frame(input logic [7:0] b, input logic stop);
    return {stop, b, 1'b0};
  endfunction

  task automatic csr_check(input string tag, input logic consume, input logic exp_busy);
    addr = 12'h7c0;
    read = consume;
    tick();
    chk({tag, "/valid"}, {31'b0, valid}, 32'd1);
    chk({tag, "/rdata"}, rdata, {22'b0, exp_busy, exp_valid, exp_data});
    addr = '0;
    read = 1'b0;
    if (consume) exp_valid = 1'b0;
  endtask

  // One frame time with optional TX (checked bit by bit) and RX stimulus.
  // rx_mode: 0 idle, 1 drive rb with stop bit rstop, 2 loop tx back to rx.
  // probe: drop a write mid-frame and read tx_busy. cons_k: loop index at
  // which a consuming read is issued (-1 for none).
  task automatic run_frame(input logic do_tx, input logic [7:0] tb, input int rx_mode,
                           input logic [7:0] rb, input logic rstop, input logic probe,
                           input int cons_k, input string tag);
    logic [9:0] tf;
    logic [9:0] rf;
    tf = frame(tb, 1'b1);
    rf = frame(rb, rstop);
    if (do_tx) begin
      addr   = 12'h7c0;
      modify = 2'b01;
      wdata  = {24'($urandom()), tb};
    end
    if (rx_mode == 1) rx = rf[0];
    tick();
    for (int k = 0; k < 10 * Div; k++) begin
      chk({tag, "/tx"}, {31'b0, tx}, {31'b0, do_tx ? tf[k / Div] : 1'b1});
      if (probe && k == 81) chk({tag, "/busy"}, {31'b0, rdata[9]}, 32'd1);
      addr   = '0;
      modify = 2'b00;
      read   = 1'b0;
      wdata  = '0;
      if (probe && k == 40) begin
        addr   = 12'h7c0;
        modify = 2'b01;
        wdata  = {24'h0, ~tb};
      end
      if (probe && k == 80) addr = 12'h7c0;
      if (k == cons_k) begin
        addr = 12'h7c0;
        read = 1'b1;
      end
      if (rx_mode == 1) rx = (k + 1 < 10 * Div) ? rf[(k + 1) / Div] : 1'b1;
      else if (rx_mode == 2) rx = tx;
      tick();
    end
    addr = '0;
    read = 1'b0;
    rx   = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    if (cons_k >= 0) exp_valid = 1'b0;
    if ((rx_mode == 1 && rstop) || rx_mode == 2) begin
      exp_valid = 1'b1;
      exp_data  = (rx_mode == 2) ? tb : rb;
    end
  endtask

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) tick();
    chk("rst/tx", {31'b0, tx}, 32'd1);
    chk("rst/valid", {31'b0, valid}, 32'd0);
    chk("rst/rdata", rdata, 32'd0);
    rstn = 1'b1;
    tick();
    csr_check("rst_read", 1'b0, 1'b0);

    read  = 1'b1;
    wdata = 32'h100;
    #1;
    chk("avoid_warning/1", {31'b0, avoid_warning}, 32'd1);
    wdata = 32'h0;
    #1;
    chk("avoid_warning/0", {31'b0, avoid_warning}, 32'd0);
    read = 1'b0;

    // Transmit 0x55 with busy probe and dropped write
    run_frame(1'b1, 8'h55, 0, 8'h00, 1'b1, 1'b1, -1, "tx55");
    csr_check("tx55_done", 1'b0, 1'b0);

    // Receive 0xA3, consume, re-read
    run_frame(1'b0, 8'h00, 1, 8'hA3, 1'b1, 1'b0, -1, "rxA3");
    csr_check("rxA3_read", 1'b1, 1'b0);
    csr_check("rxA3_reread", 1'b0, 1'b0);

    // Glitch on rx
    rx = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rx = 1'b1;
    for (int i = 0; i < 12 * Div; i++) tick();
    csr_check("glitch", 1'b0, 1'b0);

    // Framing error
    run_frame(1'b0, 8'h00, 1, 8'h3C, 1'b0, 1'b0, -1, "frame_err");
    csr_check("frame_err", 1'b0, 1'b0);

    // Overrun, then consuming read on the stop-sample cycle
    run_frame(1'b0, 8'h00, 1, 8'h11, 1'b1, 1'b0, -1, "rx11");
    run_frame(1'b0, 8'h00, 1, 8'h22, 1'b1, 1'b0, -1, "rx22");
    csr_check("overrun", 1'b0, 1'b0);
    run_frame(1'b0, 8'h00, 1, 8'h33, 1'b1, 1'b0, 153, "rx33");
    csr_check("read_vs_new", 1'b1, 1'b0);

    // Address miss
    addr   = 12'h7c1;
    modify = 2'b01;
    wdata  = 32'h5A;
    tick();
    chk("miss/valid", {31'b0, valid}, 32'd0);
    chk("miss/rdata", rdata, 32'd0);
    addr   = '0;
    modify = 2'b00;
    wdata  = '0;
    for (int i = 0; i < 3 * Div; i++) begin
      tick();
      chk("miss/tx", {31'b0, tx}, 32'd1);
    end
    csr_check("miss_status", 1'b0, 1'b0);

    // Randomized full-duplex / loopback frames
    for (int n = 0; n < 8; n++) begin
      int         mode;
      logic       dtx;
      logic       stp;
      logic [7:0] tbyte;
      logic [7:0] rbyte;
      mode  = int'($urandom_range(0, 2));
      dtx   = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      stp   = ($urandom_range(0, 3) != 0);
      tbyte = 8'($urandom());
      rbyte = 8'($urandom());
      run_frame(dtx, tbyte, mode, rbyte, stp, 1'b0, -1, "rand");
      csr_check("rand_read", 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a transmission
    addr   = 12'h7c0;
    modify = 2'b01;
    wdata  = 32'h00;
    tick();
    addr   = '0;
    modify = 2'b00;
    for (int i = 0; i < 30; i++) tick();
    chk("midrst/tx_before", {31'b0, tx}, 32'd0);
    rstn = 1'b0;
    tick();
    chk("midrst/tx", {31'b0, tx}, 32'd1);
    chk("midrst/valid", {31'b0, valid}, 32'd0);
    chk("midrst/rdata", rdata, 32'd0);
    rstn      = 1'b1;
    exp_valid = 1'b0;
    exp_data  = '0;
    for (int i = 0; i < 2 * Div; i++) begin
      tick();
      chk("midrst/tx_idle", {31'b0, tx}, 32'd1);
    end
    csr_check("midrst_status", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
